// File: rtl/reg_share_arbiter_if.sv
// Bundle of the request, grant and write-data signals shared between
// four requesting datapath units and the shared-register arbiter.
interface reg_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [3:0]         lock;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         gnt;
    logic [1:0]         owner;
    logic               busy;
    logic [3:0]         wr_ack;
    logic [WIDTH-1:0]   Q;

    // Requester side: drives requests and data, observes grants.
    modport master (
        output req, lock, wdata,
        input  gnt, owner, busy, wr_ack, Q
    );

    // Arbiter side: samples requests and data, drives grants and storage.
    modport slave (
        input  req, lock, wdata,
        output gnt, owner, busy, wr_ack, Q
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among four requesters.
// A granted owner writes its lane each cycle it keeps req high; lock lets it
// stay for up to MAX_HOLD writes, after which priority rotates past it.
module reg_share_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              sync_reset,
    reg_share_arbiter_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    // Last hold count value at which a locked owner may still continue.
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           r_state;
    logic [1:0]       r_owner;
    logic [1:0]       r_ptr;
    logic [3:0]       r_hold_cnt;
    logic [3:0]       r_gnt;
    logic [3:0]       r_wr_ack;
    logic [WIDTH-1:0] r_q;

    logic [WIDTH-1:0] w_lane [4];
    logic [3:0]       w_rot_req;
    logic [1:0]       w_base;
    logic [1:0]       w_offset;
    logic [1:0]       w_winner;
    logic             w_found;
    logic             w_owner_req;
    logic             w_keep;

    // Unpack the write-data lanes and build the request vector rotated so
    // that bit 0 is the highest-priority requester of the current search.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi]    = bus.wdata[gi*WIDTH +: WIDTH];
            assign w_rot_req[gi] = bus.req[w_base + 2'(gi)];
        end
    endgenerate

    // On release the search starts just past the outgoing owner, which is
    // exactly the pointer value written at that same edge.
    assign w_base      = (r_state == ST_OWN) ? (r_owner + 2'd1) : r_ptr;
    assign w_owner_req = bus.req[r_owner];
    assign w_keep      = (r_state == ST_OWN) && w_owner_req && bus.lock[r_owner]
                         && (r_hold_cnt < HOLD_LAST);

    // First set request in rotated order wins.
    always_comb begin
        w_found  = |w_rot_req;
        w_offset = 2'd3;
        if (w_rot_req[0])      w_offset = 2'd0;
        else if (w_rot_req[1]) w_offset = 2'd1;
        else if (w_rot_req[2]) w_offset = 2'd2;
        w_winner = w_base + w_offset;
    end

    // Grant state machine, shared-register write and write acknowledge.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= 2'd0;
            r_ptr      <= 2'd0;
            r_hold_cnt <= 4'd0;
            r_gnt      <= 4'd0;
            r_wr_ack   <= 4'd0;
            r_q        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wr_ack <= 4'd0;
                    if (w_found) begin
                        r_state    <= ST_OWN;
                        r_owner    <= w_winner;
                        r_hold_cnt <= 4'd0;
                        r_gnt      <= 4'b0001 << w_winner;
                    end
                end
                ST_OWN: begin
                    if (w_owner_req) begin
                        r_q      <= w_lane[r_owner];
                        r_wr_ack <= 4'b0001 << r_owner;
                    end else begin
                        r_wr_ack <= 4'd0;
                    end
                    if (w_keep) begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                    end else begin
                        r_ptr      <= r_owner + 2'd1;
                        r_hold_cnt <= 4'd0;
                        if (w_found) begin
                            r_owner <= w_winner;
                            r_gnt   <= 4'b0001 << w_winner;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= 4'd0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.owner  = r_owner;
    assign bus.busy   = |r_gnt;
    assign bus.wr_ack = r_wr_ack;
    assign bus.Q      = r_q;
endmodule
